mem_port_arbiter: RTL and testbench

Shares one single-ported, synchronous-read memory between the Riscv151 instruction-fetch port and the load/store data port. It grants at most one access per cycle, with priority to data accesses and a bounded-starvation guard for fetch. It routes the one-cycle-latency read data back to whichever port issued the read, and counts fetch-denied cycles for performance debug. It sits between the CPU pipeline and the BIOS/data memory macro.

---
 rtl/riscv151_mem_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 92 +++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv151_mem_pkg.sv
// Shared definitions for the Riscv151 memory-port arbitration logic.
package riscv151_mem_pkg;

    localparam int unsigned BE_W   = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous-read memory between instruction fetch and load/store,
// routing one-cycle-latency read data back to the port that issued the read.
module mem_port_arbiter
    import riscv151_mem_pkg::*;
#(
    parameter int unsigned AW           = 12,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic [BE_W-1:0]   d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,

    output logic [31:0]       fetch_stall_cnt
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    owner_e        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   stall_q, stall_d;
    logic          starved;
    logic          if_denied;

    // Data normally wins a collision; a fetch that has waited LIMIT cycles takes the slot.
    assign starved   = (starve_q == LIMIT);
    assign if_gnt    = if_req & (~d_req | starved);
    assign d_gnt     = d_req & ~(if_req & starved);
    assign if_denied = if_req & ~if_gnt;

    always_comb begin
        mem_en   = if_gnt | d_gnt;
        mem_addr = if_gnt ? if_addr : d_addr;
        mem_we   = d_gnt ? d_we : '0;
        mem_din  = d_wdata;
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt && (d_we == '0)) begin
            owner_d = OWN_D;
        end
    end

    always_comb begin
        starve_d = '0;
        if (if_denied) begin
            starve_d = starved ? starve_q : starve_q + SW'(1);
        end
        stall_d = stall_q + {31'd0, if_denied};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            stall_q  <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign if_rvalid       = (owner_q == OWN_IF);
    assign d_rvalid        = (owner_q == OWN_D);
    assign if_rdata        = mem_dout;
    assign d_rdata         = mem_dout;
    assign fetch_stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a behavioural memory macro
// and a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW    = 12;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0;
    logic [3:0]    d_we = '0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;
    logic [31:0]   fetch_stall_cnt;

    mem_port_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .fetch_stall_cnt(fetch_stall_cnt)
    );

    always #5 clk = ~clk;

    // Memory macro: synchronous read, byte-enabled write, plus a preload port.
    logic [31:0]   macro_mem [0:(1<<AW)-1];
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;

    always @(posedge clk) begin
        if (load_en) begin
            macro_mem[load_addr] <= load_data;
        end else if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_dout <= macro_mem[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) macro_mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
                end
            end
        end
    end

    // Reference model state
    logic [31:0] shadow [0:255];
    int          fwait;
    logic [31:0] stall_model;
    logic        pend_if, pend_d;
    logic [31:0] pend_if_data, pend_d_data;
    logic        g_if, g_d;
    logic [31:0] last_if_rdata, last_d_rdata;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive requests, check at the falling edge, advance the model.
    task automatic step(input logic ifr, input logic [AW-1:0] ia, input logic dr,
                        input logic [3:0] we, input logic [AW-1:0] da, input logic [31:0] wd);
        logic ei, ed;
        if_req = ifr; if_addr = ia;
        d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
        @(negedge clk);
        ei = ifr && (!dr || fwait == LIMIT);
        ed = dr && !ei;
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, ei});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, ed});
        chk("mem_en", {31'd0, mem_en}, {31'd0, ei | ed});
        chk("mem_we", {28'd0, mem_we}, ed ? {28'd0, we} : 32'd0);
        if (ei) chk("mem_addr_if", {20'd0, mem_addr}, {20'd0, ia});
        if (ed) chk("mem_addr_d", {20'd0, mem_addr}, {20'd0, da});
        if (ed && we != 4'b0) chk("mem_din", mem_din, wd);
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, pend_if});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, pend_d});
        if (pend_if) begin
            chk("if_rdata", if_rdata, pend_if_data);
            last_if_rdata = if_rdata;
        end
        if (pend_d) begin
            chk("d_rdata", d_rdata, pend_d_data);
            last_d_rdata = d_rdata;
        end
        chk("fetch_stall_cnt", fetch_stall_cnt, stall_model);

        pend_if      = ei;
        pend_if_data = shadow[ia[7:0]];
        pend_d       = ed && (we == 4'b0);
        pend_d_data  = shadow[da[7:0]];
        if (ed && we != 4'b0) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) shadow[da[7:0]][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if (ifr && !ei) begin
            stall_model = stall_model + 32'd1;
            fwait = (fwait < LIMIT) ? fwait + 1 : LIMIT;
        end else begin
            fwait = 0;
        end
        g_if = if_gnt;
        g_d  = d_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 4'b0, '0, 32'd0);
    endtask

    initial begin
        logic [9:0]    pattern;
        logic [31:0]   stall_base;
        logic          p_if, p_d;
        logic [AW-1:0] p_ia, p_da;
        logic [3:0]    p_we;
        logic [31:0]   p_wd;

        fwait = 0; stall_model = '0;
        pend_if = 1'b0; pend_d = 1'b0;
        pend_if_data = '0; pend_d_data = '0;
        last_if_rdata = '0; last_d_rdata = '0;
        g_if = 1'b0; g_d = 1'b0;

        for (int i = 0; i < 256; i++) shadow[i] = $urandom;
        shadow[8'h10] = 32'h0000_0013;
        shadow[8'h30] = 32'h1122_3344;

        // Preload the macro while the arbiter is held in reset.
        @(posedge clk); #1;
        load_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            load_addr = AW'(i);
            load_data = shadow[i];
            @(posedge clk); #1;
        end
        load_en = 1'b0;

        chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rst_stall", fetch_stall_cnt, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        rst = 1'b1;
        idle();

        // Lone fetch
        step(1'b1, 12'h010, 1'b0, 4'b0, '0, 32'd0);
        idle();
        chk("tp_fetch_data", last_if_rdata, 32'h0000_0013);

        // Write then read back
        step(1'b0, '0, 1'b1, 4'hF, 12'h020, 32'hDEAD_BEEF);
        step(1'b0, '0, 1'b1, 4'h0, 12'h020, 32'd0);
        idle();
        chk("tp_wr_rd_data", last_d_rdata, 32'hDEAD_BEEF);

        // Continuous contention
        stall_base = stall_model;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 12'h002, 1'b1, 4'h0, 12'h001, 32'd0);
            pattern[c] = g_if;
        end
        idle();
        chk("tp_contention_pattern", {22'd0, pattern}, 32'h0000_0210);
        chk("tp_contention_stalls", stall_model - stall_base, 32'd8);

        // Byte write
        step(1'b0, '0, 1'b1, 4'b0010, 12'h030, 32'h0000_AB00);
        step(1'b0, '0, 1'b1, 4'h0, 12'h030, 32'd0);
        idle();
        chk("tp_byte_write", last_d_rdata, 32'h1122_AB44);

        // Reset between a read grant and its return
        step(1'b1, 12'h010, 1'b0, 4'b0, '0, 32'd0);
        if_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("tp_rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("tp_rst_stall", fetch_stall_cnt, 32'd0);
        #2;
        rst = 1'b1;
        pend_if = 1'b0; pend_d = 1'b0; fwait = 0; stall_model = '0;
        idle();

        // Alternating single requests
        stall_base = stall_model;
        step(1'b1, 12'h010, 1'b0, 4'b0, '0, 32'd0);
        step(1'b0, '0, 1'b1, 4'h0, 12'h020, 32'd0);
        step(1'b1, 12'h030, 1'b0, 4'b0, '0, 32'd0);
        idle();
        chk("tp_alt_stalls", stall_model - stall_base, 32'd0);
        chk("tp_alt_if_data", last_if_rdata, 32'h1122_AB44);
        chk("tp_alt_d_data", last_d_rdata, 32'hDEAD_BEEF);

        // Randomized traffic, requests held until granted
        p_if = 1'b0; p_d = 1'b0;
        p_ia = '0; p_da = '0; p_we = '0; p_wd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!p_if && ($urandom_range(0, 3) != 0)) begin
                p_if = 1'b1;
                p_ia = AW'($urandom_range(0, 255));
            end
            if (!p_d && ($urandom_range(0, 2) != 0)) begin
                p_d  = 1'b1;
                p_da = AW'($urandom_range(0, 255));
                p_we = ($urandom_range(0, 1) != 0) ? 4'b0 : 4'($urandom_range(1, 15));
                p_wd = $urandom;
            end
            step(p_if, p_ia, p_d, p_we, p_da, p_wd);
            if (g_if) p_if = 1'b0;
            if (g_d)  p_d  = 1'b0;
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
